// File: rtl/config_reg_bank.sv
// config_reg_bank: bank of shadow configuration registers plus an active copy.
// Writes land in the shadow set. A commit copies every shadow register into
// the active set at once, so active_flat only changes on a commit. A sticky
// lock blocks later writes and commits and is cleared only by reset.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   write       write request; data_in goes to shadow[address]
//   read        read request; data_out/rd_valid follow one cycle later
//   address     register index for read and write
//   data_in     write data
//   commit      copy all shadow registers to the active registers
//   lock        set the sticky lock
//   data_out    registered read data; holds its value when rd_valid is 0
//   rd_valid    one-cycle pulse marking data_out as valid
//   err         one-cycle pulse for an illegal write and/or an illegal read
//   locked      sticky lock status
//   active_flat active registers; register i is at [i*DATA_W +: DATA_W]
module config_reg_bank #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       NUM_REGS  = 8,
  parameter int unsigned       ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write,
  input  logic                       read,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       commit,
  input  logic                       lock,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic                       err,
  output logic                       locked,
  output logic [NUM_REGS*DATA_W-1:0] active_flat
);

  logic [DATA_W-1:0] r_shadow [NUM_REGS];
  logic [DATA_W-1:0] r_active [NUM_REGS];
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_err;
  logic              r_locked;

  logic              w_addr_ok;
  logic              w_wr_en;
  logic              w_wr_err;
  logic              w_rd_err;
  logic              w_commit_en;
  logic [DATA_W-1:0] w_rd_data;

  // Request qualification; lock only affects requests from the next cycle on.
  assign w_addr_ok   = 32'(address) < NUM_REGS;
  assign w_wr_en     = write & ~r_locked & w_addr_ok;
  assign w_wr_err    = write & (r_locked | ~w_addr_ok);
  assign w_rd_err    = read & ~w_addr_ok;
  assign w_commit_en = commit & ~r_locked;

  // Read mux over the pre-edge shadow values; out-of-range reads yield zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (address == ADDR_W'(i)) begin
        w_rd_data = r_shadow[i];
      end
    end
  end

  // Shadow and active storage. Commit samples shadow before this edge's write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_shadow[i] <= RESET_VAL;
        r_active[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (w_wr_en && (address == ADDR_W'(i))) begin
          r_shadow[i] <= data_in;
        end
        if (w_commit_en) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  // Read response, error pulse and sticky lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      if (read) begin
        r_data_out <= w_rd_data;
      end
      r_rd_valid <= read;
      r_err      <= w_wr_err | w_rd_err;
      r_locked   <= r_locked | lock;
    end
  end

  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;
  assign locked   = r_locked;

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign active_flat[g*DATA_W +: DATA_W] = r_active[g];
  end

endmodule

// File: tb/tb_config_reg_bank.sv
// Randomized bench for config_reg_bank. Two instances share one stimulus
// stream: the default 8-register bank and a 6-register bank, so addresses
// 6 and 7 exercise the out-of-range paths. A plain array model predicts
// every output after each clock edge.
module tb_config_reg_bank;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [2:0]    address = '0;
  logic [DW-1:0] data_in = '0;
  logic          commit = 1'b0;
  logic          lock = 1'b0;

  logic [DW-1:0] dout [2];
  logic          rv [2];
  logic          er [2];
  logic          lk [2];
  logic [127:0]  af0;
  logic [95:0]   af1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain arrays, one slice per instance.
  logic [DW-1:0] m_sh  [2][8];
  logic [DW-1:0] m_act [2][8];
  logic          m_lock [2];
  logic [DW-1:0] m_dout [2];
  logic          m_rv [2];
  logic          m_err [2];

  always #5 clk = ~clk;

  config_reg_bank u_dut8 (
    .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
    .data_in(data_in), .commit(commit), .lock(lock), .data_out(dout[0]),
    .rd_valid(rv[0]), .err(er[0]), .locked(lk[0]), .active_flat(af0)
  );

  config_reg_bank #(.NUM_REGS(6)) u_dut6 (
    .clk(clk), .reset(reset), .write(write), .read(read), .address(address),
    .data_in(data_in), .commit(commit), .lock(lock), .data_out(dout[1]),
    .rd_valid(rv[1]), .err(er[1]), .locked(lk[1]), .active_flat(af1)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nregs(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_sh[k][i]  = '0;
        m_act[k][i] = '0;
      end
      m_lock[k] = 1'b0;
      m_dout[k] = '0;
      m_rv[k]   = 1'b0;
      m_err[k]  = 1'b0;
    end
  endtask

  // Apply the rules for one clock edge using the inputs that were held across it.
  task automatic model_edge();
    logic [DW-1:0] old_sh [8];
    int  a;
    bit  in_range, wr_bad, rd_bad;
    a = int'(address);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) old_sh[i] = m_sh[k][i];
      in_range = a < nregs(k);
      wr_bad   = write && (m_lock[k] || !in_range);
      rd_bad   = read && !in_range;
      if (read) m_dout[k] = in_range ? old_sh[a] : '0;
      m_rv[k]  = read;
      m_err[k] = wr_bad || rd_bad;
      if (write && !wr_bad) m_sh[k][a] = data_in;
      if (commit && !m_lock[k]) begin
        for (int i = 0; i < nregs(k); i++) m_act[k][i] = old_sh[i];
      end
      m_lock[k] = m_lock[k] || lock;
    end
  endtask

  task automatic check_all(input string tag);
    logic [255:0] exp_flat;
    for (int k = 0; k < 2; k++) begin
      exp_flat = '0;
      for (int i = 0; i < nregs(k); i++) exp_flat[i*DW +: DW] = m_act[k][i];
      chk($sformatf("%s_i%0d_dout", tag, k), 256'(dout[k]), 256'(m_dout[k]));
      chk($sformatf("%s_i%0d_rv", tag, k), 256'(rv[k]), 256'(m_rv[k]));
      chk($sformatf("%s_i%0d_err", tag, k), 256'(er[k]), 256'(m_err[k]));
      chk($sformatf("%s_i%0d_lock", tag, k), 256'(lk[k]), 256'(m_lock[k]));
      if (k == 0) chk($sformatf("%s_i0_act", tag), 256'(af0), exp_flat);
      else        chk($sformatf("%s_i1_act", tag), 256'(af1), exp_flat);
    end
  endtask

  // Called at posedge+1: drive one cycle of inputs, advance an edge, check.
  task automatic step(input string tag, input logic w, input logic r, input logic [2:0] a,
                      input logic [DW-1:0] d, input logic c, input logic l);
    write = w; read = r; address = a; data_in = d; commit = c; lock = l;
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  // Reset asserted between edges while requests are driven; checked before the next edge.
  task automatic mid_reset(input string tag);
    write = 1'b1; read = 1'b1; commit = 1'b1; lock = 1'b1;
    address = 3'd3; data_in = 16'h5A5A;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #2;
    write = 1'b0; read = 1'b0; commit = 1'b0; lock = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("por");
    #13;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Write then read, active held until commit.
    step("w2", 1, 0, 3'd2, 16'h1234, 0, 0);
    step("r2", 0, 1, 3'd2, 16'h0000, 0, 0);
    chk("d_r2_dout", 256'(dout[0]), 256'(16'h1234));
    chk("d_r2_rv", 256'(rv[0]), 256'(1'b1));
    chk("d_act2_pre", 256'(af0[47:32]), 256'(16'h0000));
    step("c1", 0, 0, 3'd0, 16'h0000, 1, 0);
    chk("d_act2_post", 256'(af0[47:32]), 256'(16'h1234));

    // Same-cycle read and write returns the old value.
    step("wr5", 1, 1, 3'd5, 16'hBEEF, 0, 0);
    chk("d_wr5_old", 256'(dout[0]), 256'(16'h0000));
    step("r5", 0, 1, 3'd5, 16'h0000, 0, 0);
    chk("d_r5_new", 256'(dout[0]), 256'(16'hBEEF));
    step("idle", 0, 0, 3'd0, 16'h0000, 0, 0);
    chk("d_hold_dout", 256'(dout[0]), 256'(16'hBEEF));

    // Write with commit in the same cycle: active gets the old shadow.
    step("wc0", 1, 0, 3'd0, 16'hAAAA, 1, 0);
    chk("d_wc0_act", 256'(af0[15:0]), 256'(16'h0000));
    step("c2", 0, 0, 3'd0, 16'h0000, 1, 0);
    chk("d_c2_act", 256'(af0[15:0]), 256'(16'hAAAA));

    // Out-of-range accesses on the 6-register instance.
    step("w7", 1, 0, 3'd7, 16'h7777, 0, 0);
    chk("d_w7_err", 256'(er[1]), 256'(1'b1));
    step("r6", 0, 1, 3'd6, 16'h0000, 0, 0);
    chk("d_r6_dout", 256'(dout[1]), 256'(16'h0000));
    chk("d_r6_err", 256'(er[1]), 256'(1'b1));
    chk("d_r6_err8", 256'(er[0]), 256'(1'b0));

    // Lock blocks later writes (with err) and commits (silently).
    step("w1", 1, 0, 3'd1, 16'h1111, 0, 1);
    step("w1lk", 1, 0, 3'd1, 16'hFFFF, 0, 0);
    chk("d_lk_err", 256'(er[0]), 256'(1'b1));
    step("r1lk", 0, 1, 3'd1, 16'h0000, 1, 0);
    chk("d_lk_r1", 256'(dout[0]), 256'(16'h1111));
    chk("d_lk_cerr", 256'(er[0]), 256'(1'b0));
    chk("d_lk_act1", 256'(af0[31:16]), 256'(16'h0000));
    chk("d_locked", 256'(lk[0]), 256'(1'b1));

    mid_reset("rst");
    chk("d_rst_locked", 256'(lk[0]), 256'(1'b0));
    chk("d_rst_act", 256'(af0), 256'(0));
    step("post", 0, 1, 3'd3, 16'h0000, 0, 0);

    // Random traffic with occasional mid-cycle resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 16'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
